axis_int2float_pair: RTL and testbench

Fully pipelined converter that turns a pair of 32-bit integers into a pair of IEEE-754 single-precision floats. It sits directly upstream of the single-precision float multiplier. Its 64-bit output beat is already packed as {operand A, operand B}, so it feeds the multiplier's AXIS slave port unchanged. It sustains one beat per cycle with 3-cycle latency and full backpressure.

---
 rtl/float_cvt_pkg.sv | 19 +
 rtl/int2float_lane.sv | 102 ++++++++++
 rtl/axis_int2float_pair.sv | 83 ++++++++
 tb/tb_axis_int2float_pair.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/float_cvt_pkg.sv
// Shared constants and rounding helper for integer-to-float conversion.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package float_cvt_pkg;

  localparam logic [7:0] FP_BIAS     = 8'd127;
  // Exponent of a value whose leading one sits at bit 31 (127 + 31).
  localparam logic [7:0] I2F_EXP_TOP = 8'd158;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;

  // Round to nearest, ties to even: bump the mantissa when above half,
  // or exactly half with an odd lsb.
  function automatic logic rne_inc(input logic g, input logic s, input logic lsb);
    return g & (s | lsb);
  endfunction

endpackage

// File: rtl/int2float_lane.sv
// One lane of int32/uint32 to IEEE-754 single conversion: sign/abs, LZC/shift, round/pack.
// Latency: 3 cycles; every register loads only when adv is high.
// Backpressure: all stages hold their contents while adv is low.
module int2float_lane
  import float_cvt_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        adv,
  input  logic        en_signed,
  input  logic [31:0] in_dat,
  output logic [31:0] out_dat,
  output logic        out_inexact
);

  logic                sign1_d, sign1_q, zero1_d, zero1_q;
  logic [31:0]         mag1_d, mag1_q;
  logic                sign2_d, sign2_q, zero2_d, zero2_q;
  logic [31:0]         norm2_d, norm2_q;
  logic [FP_EXP_W-1:0] exp2_d, exp2_q;
  logic [31:0]         res3_d, res3_q;
  logic                inx3_d, inx3_q;

  logic [4:0]          lzc;
  logic [FP_MAN_W-1:0] mant, mant_r;
  logic                guard, sticky, carry;
  logic [FP_EXP_W-1:0] exp_r;

  // Stage 1: sign capture and magnitude; -2^31 naturally yields 0x80000000.
  always_comb begin
    sign1_d = sign1_q;
    mag1_d  = mag1_q;
    zero1_d = zero1_q;
    if (adv) begin
      sign1_d = en_signed & in_dat[31];
      mag1_d  = sign1_d ? (~in_dat + 32'd1) : in_dat;
      zero1_d = (in_dat == 32'd0);
    end
  end

  // Stage 2: leading-zero count, normalise so the leading one lands at bit 31.
  always_comb begin
    lzc = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (mag1_q[i]) lzc = 5'(31 - i);
    end
    sign2_d = sign2_q;
    zero2_d = zero2_q;
    norm2_d = norm2_q;
    exp2_d  = exp2_q;
    if (adv) begin
      sign2_d = sign1_q;
      zero2_d = zero1_q;
      norm2_d = mag1_q << lzc;
      exp2_d  = I2F_EXP_TOP - {3'b000, lzc};
    end
  end

  // Stage 3: drop the hidden bit, round RNE, pack; zero forces +0 and exact.
  always_comb begin
    mant          = norm2_q[30:8];
    guard         = norm2_q[7];
    sticky        = |norm2_q[6:0];
    {carry, mant_r} = {1'b0, mant} + {{FP_MAN_W{1'b0}}, rne_inc(guard, sticky, mant[0])};
    exp_r         = carry ? (exp2_q + 8'd1) : exp2_q;
    res3_d        = res3_q;
    inx3_d        = inx3_q;
    if (adv) begin
      res3_d = zero2_q ? 32'd0 : {sign2_q, exp_r, mant_r};
      inx3_d = ~zero2_q & (guard | sticky);
    end
  end

  // Pipeline registers for all three stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign1_q <= 1'b0;
      mag1_q  <= 32'd0;
      zero1_q <= 1'b0;
      sign2_q <= 1'b0;
      zero2_q <= 1'b0;
      norm2_q <= 32'd0;
      exp2_q  <= '0;
      res3_q  <= 32'd0;
      inx3_q  <= 1'b0;
    end else begin
      sign1_q <= sign1_d;
      mag1_q  <= mag1_d;
      zero1_q <= zero1_d;
      sign2_q <= sign2_d;
      zero2_q <= zero2_d;
      norm2_q <= norm2_d;
      exp2_q  <= exp2_d;
      res3_q  <= res3_d;
      inx3_q  <= inx3_d;
    end
  end

  assign out_dat     = res3_q;
  assign out_inexact = inx3_q;

endmodule

// File: rtl/axis_int2float_pair.sv
// AXIS converter of an int32 pair {A,B} into a packed single-float pair for the multiplier.
// Latency: 3 cycles from acceptance, one beat per cycle sustained.
// Backpressure: whole pipe stalls while the output beat waits; s_axis_ready = ~stall & ~rst.
module axis_int2float_pair
  import float_cvt_pkg::*;
#(
  parameter string en_signed        = "true",
  parameter real   simulation_delay = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] s_axis_data,
  input  logic        s_axis_last,
  input  logic        s_axis_valid,
  output logic        s_axis_ready,
  output logic [63:0] m_axis_data,
  output logic [1:0]  m_axis_user,
  output logic        m_axis_last,
  output logic        m_axis_valid,
  input  logic        m_axis_ready
);

  // Register update delay is a simulation-model notion; RTL registers update at the edge.
  if (simulation_delay < 0.0) begin : g_bad_delay
    $error("simulation_delay must be non-negative");
  end

  localparam logic SIGNED_MODE = (en_signed == "true");

  logic       stall, adv;
  logic [2:0] vld_d, vld_q;
  logic [2:0] last_d, last_q;

  // Only the output stage can block, so one global advance keeps all stages in lockstep.
  assign stall        = vld_q[2] & ~m_axis_ready;
  assign adv          = ~stall;
  assign s_axis_ready = ~stall & ~rst;

  // Valid and last shift together with the datapath; bubbles are not squeezed out.
  always_comb begin
    vld_d  = vld_q;
    last_d = last_q;
    if (adv) begin
      vld_d  = {vld_q[1:0], s_axis_valid};
      last_d = {last_q[1:0], s_axis_last};
    end
  end

  // Sideband registers; reset flushes every in-flight beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 3'b000;
      last_q <= 3'b000;
    end else begin
      vld_q  <= vld_d;
      last_q <= last_d;
    end
  end

  int2float_lane u_lane_a (
    .clk         (clk),
    .rst         (rst),
    .adv         (adv),
    .en_signed   (SIGNED_MODE),
    .in_dat      (s_axis_data[63:32]),
    .out_dat     (m_axis_data[63:32]),
    .out_inexact (m_axis_user[1])
  );

  int2float_lane u_lane_b (
    .clk         (clk),
    .rst         (rst),
    .adv         (adv),
    .en_signed   (SIGNED_MODE),
    .in_dat      (s_axis_data[31:0]),
    .out_dat     (m_axis_data[31:0]),
    .out_inexact (m_axis_user[0])
  );

  assign m_axis_valid = vld_q[2];
  assign m_axis_last  = last_q[2];

endmodule

// File: tb/tb_axis_int2float_pair.sv
// Directed bench for axis_int2float_pair: vectors, backpressure, mid-stream reset, streaming.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// A signed and an unsigned instance share all inputs.
module tb_axis_int2float_pair;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s_data;
  logic        s_last, s_valid, s_ready, s_ready_u;
  logic [63:0] m_data, m_data_u;
  logic [1:0]  m_user, m_user_u;
  logic        m_last, m_last_u, m_valid, m_valid_u;
  logic        m_ready;

  always #5 clk = ~clk;

  axis_int2float_pair dut (
    .clk(clk), .rst(rst),
    .s_axis_data(s_data), .s_axis_last(s_last), .s_axis_valid(s_valid), .s_axis_ready(s_ready),
    .m_axis_data(m_data), .m_axis_user(m_user), .m_axis_last(m_last),
    .m_axis_valid(m_valid), .m_axis_ready(m_ready)
  );

  axis_int2float_pair #(.en_signed("false")) dut_u (
    .clk(clk), .rst(rst),
    .s_axis_data(s_data), .s_axis_last(s_last), .s_axis_valid(s_valid), .s_axis_ready(s_ready_u),
    .m_axis_data(m_data_u), .m_axis_user(m_user_u), .m_axis_last(m_last_u),
    .m_axis_valid(m_valid_u), .m_axis_ready(m_ready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Hand-computed vectors: {A, B} in, {fA, fB} and {inxA, inxB} out.
  logic [31:0] ta[10] = '{32'h00000001, 32'h7FFFFFFF, 32'h01000001, 32'h00000000, 32'h00000002,
                          32'h00000003, 32'h00000064, 32'h01000000, 32'h01000002, 32'h01000005};
  logic [31:0] tb[10] = '{32'hFFFFFFFF, 32'h80000000, 32'h01000003, 32'h00000000, 32'hFFFFFFFE,
                          32'h0000000A, 32'hFFFFFF9C, 32'h000000FF, 32'hFFFFFFFF, 32'h00000400};
  logic [31:0] ea[10] = '{32'h3F800000, 32'h4F000000, 32'h4B800000, 32'h00000000, 32'h40000000,
                          32'h40400000, 32'h42C80000, 32'h4B800000, 32'h4B800001, 32'h4B800002};
  logic [31:0] eb[10] = '{32'hBF800000, 32'hCF000000, 32'h4B800002, 32'h00000000, 32'hC0000000,
                          32'h41200000, 32'hC2C80000, 32'h437F0000, 32'hBF800000, 32'h44800000};
  logic [1:0]  eu[10] = '{2'b00, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};

  // Exact conversion of small integers through the simulator's double format.
  function automatic logic [31:0] f_small(input int x);
    logic [63:0] b;
    logic [10:0] e11;
    if (x == 0) return 32'd0;
    b   = $realtobits($itor(x));
    e11 = b[62:52];
    return {b[63], 8'(e11 - 11'd896), b[51:29]};
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Output monitor: records handshakes and checks that stalled beats hold still.
  logic [63:0] got_d[$], got_du[$];
  logic [1:0]  got_u[$], got_uu[$];
  logic        got_l[$];
  int          got_c[$];
  logic        stalled = 1'b0;
  logic [63:0] hold_d;
  logic [1:0]  hold_u;
  logic        hold_l;

  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_hold_data", m_data, hold_d);
        check("stall_hold_side", {61'd0, m_valid, m_last, m_user}, {61'd0, 1'b1, hold_l, hold_u});
      end
      stalled = m_valid && !m_ready;
      hold_d  = m_data;
      hold_u  = m_user;
      hold_l  = m_last;
      if (m_valid && m_ready) begin
        got_d.push_back(m_data);
        got_du.push_back(m_data_u);
        got_u.push_back(m_user);
        got_uu.push_back(m_user_u);
        got_l.push_back(m_last);
        got_c.push_back(cyc);
      end
    end
  end

  task automatic clear_got();
    got_d.delete(); got_du.delete(); got_u.delete(); got_uu.delete();
    got_l.delete(); got_c.delete();
  endtask

  // Presents one beat until accepted; entered and left 1 unit after a rising edge.
  task automatic send(input logic [63:0] d, input logic l, output int acc_cyc);
    int  guard = 0;
    bit  done  = 0;
    acc_cyc = -1;
    s_data  = d;
    s_last  = l;
    s_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (s_ready) begin
        acc_cyc = cyc;
        done    = 1;
      end else if (++guard > 500) begin
        check("send_timeout", 64'd0, 64'd1);
        done = 1;
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int guard = 0;
    while (got_d.size() < n && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (got_d.size() < n) check("wait_out_timeout", 64'(got_d.size()), 64'(n));
  endtask

  task automatic check_table(input string ph);
    check({ph, "_count"}, 64'(got_d.size()), 64'd10);
    for (int i = 0; i < 10 && i < got_d.size(); i++) begin
      check($sformatf("%s_data%0d", ph, i), got_d[i], {ea[i], eb[i]});
      check($sformatf("%s_user%0d", ph, i), {62'd0, got_u[i]}, {62'd0, eu[i]});
      check($sformatf("%s_last%0d", ph, i), {63'd0, got_l[i]}, {63'd0, i == 9});
    end
    if (got_d.size() > 1) begin
      check({ph, "_unsigned_data"}, got_du[1], {32'h4F000000, 32'h4F000000});
      check({ph, "_unsigned_user"}, {62'd0, got_uu[1]}, 64'd2);
    end
  endtask

  int  acc0, acc_tmp, errs;
  bit  bp_done;

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 64'd0; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_m_valid", {63'd0, m_valid}, 64'd0);
    check("rst_m_data",  m_data, 64'd0);
    check("rst_m_user",  {62'd0, m_user}, 64'd0);
    check("rst_m_last",  {63'd0, m_last}, 64'd0);
    check("rst_s_ready", {63'd0, s_ready}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Table with free-flowing output, back to back, last on the tenth beat.
    clear_got();
    for (int i = 0; i < 10; i++) begin
      send({ta[i], tb[i]}, i == 9, acc_tmp);
      if (i == 0) acc0 = acc_tmp;
    end
    wait_out(10);
    repeat (5) @(posedge clk); #1;
    if (got_c.size() > 0) check("latency", 64'(got_c[0] - acc0), 64'd3);
    check_table("flow");

    // Same table with pseudo-random output backpressure.
    clear_got();
    bp_done = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) send({ta[i], tb[i]}, i == 9, acc_tmp);
        bp_done = 1;
      end
      begin
        while (!bp_done) begin
          m_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
    join
    m_ready = 1'b1;
    wait_out(10);
    repeat (8) @(posedge clk); #1;
    check_table("bp");

    // Reset with three beats parked in the pipe.
    clear_got();
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) send({ta[i + 4], tb[i + 4]}, 1'b0, acc_tmp);
    repeat (2) @(posedge clk);
    #3;
    check("pre_rst_valid", {63'd0, m_valid}, 64'd1);
    rst = 1'b1;
    #1;
    check("arst_m_valid", {63'd0, m_valid}, 64'd0);
    check("arst_m_data",  m_data, 64'd0);
    check("arst_m_side",  {61'd0, m_user, m_last}, 64'd0);
    check("arst_s_ready", {63'd0, s_ready}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_ready = 1'b1;
    repeat (10) @(posedge clk); #1;
    check("post_rst_idle", 64'(got_d.size()), 64'd0);
    send({ta[5], tb[5]}, 1'b1, acc_tmp);
    wait_out(1);
    repeat (5) @(posedge clk); #1;
    check("post_rst_count", 64'(got_d.size()), 64'd1);
    if (got_d.size() > 0) check("post_rst_data", got_d[0], {ea[5], eb[5]});

    // 100-beat continuous stream.
    clear_got();
    for (int i = 1; i <= 100; i++) send({32'(i), 32'(-i)}, i == 100, acc_tmp);
    wait_out(100);
    repeat (5) @(posedge clk); #1;
    check("stream_count", 64'(got_d.size()), 64'd100);
    errs = 0;
    for (int i = 0; i < got_d.size(); i++) begin
      if (got_d[i] !== {f_small(i + 1), f_small(-(i + 1))}) errs++;
      if (i > 0 && got_c[i] != got_c[i - 1] + 1) errs++;
    end
    check("stream_data_and_gaps", 64'(errs), 64'd0);
    if (got_l.size() == 100) check("stream_last", {63'd0, got_l[99]}, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
